// File: rtl/record_instrument.sv
// rtl/record_instrument.sv - AC97 mic capture packed four-per-word into ZBT memory
//
// Ports:
//   clock           system clock (27 MHz)
//   reset           asynchronous active-low reset
//   start           pulse: begin a new take at base_address (honoured in IDLE/DONE)
//   stop            pulse: end the take early, flushing a partial word
//   ready           strobe: from_ac97_data carries a valid sample
//   base_address    first ZBT word address of the take
//   from_ac97_data  8-bit PCM sample
//   we_ZBT          active-low ZBT write enable, low for one cycle per word
//   address         ZBT word address (base + words_written, wraps mod 2^ADDR_W)
//   data_out        packed word {4'b0, lane0, lane1, lane2, lane3}
//   recording       high in REC
//   done            high in DONE
//   words_written   words committed in the current/last take (playback length)

module record_instrument #(
    parameter int RECORDING_LEN = 32768,
    parameter int ADDR_W        = 19
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              stop,
    input  logic              ready,
    input  logic [ADDR_W-1:0] base_address,
    input  logic [7:0]        from_ac97_data,
    output logic              we_ZBT,
    output logic [ADDR_W-1:0] address,
    output logic [35:0]       data_out,
    output logic              recording,
    output logic              done,
    output logic [ADDR_W-1:0] words_written
);

    typedef enum logic [1:0] {IDLE, REC, FLUSH, DONE} state_t;

    state_t            state;
    state_t            state_next;
    logic [1:0]        lane;
    logic [ADDR_W-1:0] base;
    logic [31:0]       pack;

    logic              capture;
    logic [1:0]        lane_upd;
    logic              word_full;
    logic              commit;
    logic              take_full;
    logic              take_start;
    logic              flush_issue;
    logic [ADDR_W-1:0] ww_inc;

    assign capture     = (state == REC) && ready;
    // Lane as it will be after this edge's capture; stop decisions use it.
    assign lane_upd    = capture ? lane + 2'd1 : lane;
    assign word_full   = capture && (lane == 2'd3);
    // A low write enable means a word is in flight; the following edge commits it.
    assign commit      = !we_ZBT;
    assign ww_inc      = words_written + ADDR_W'(1);
    assign take_full   = commit && (ww_inc == ADDR_W'(RECORDING_LEN));
    assign take_start  = start && ((state == IDLE) || (state == DONE));
    // On entry to FLUSH we_ZBT is high, so high here means the flush write is not yet issued.
    assign flush_issue = (state == FLUSH) && we_ZBT;

    assign recording   = (state == REC);
    assign done        = (state == DONE);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE, DONE: begin
                if (start) state_next = REC;
            end
            REC: begin
                if (take_full)     state_next = DONE;
                else if (stop)     state_next = (lane_upd != 2'd0) ? FLUSH : DONE;
            end
            FLUSH: begin
                if (commit)        state_next = DONE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            we_ZBT        <= 1'b1;
            address       <= '0;
            data_out      <= '0;
            words_written <= '0;
            lane          <= 2'd0;
            base          <= '0;
            pack          <= '0;
        end else if (take_start) begin
            base          <= base_address;
            words_written <= '0;
            lane          <= 2'd0;
            pack          <= '0;
            we_ZBT        <= 1'b1;
        end else begin
            if (commit) begin
                we_ZBT        <= 1'b1;
                words_written <= ww_inc;
            end
            if (capture) begin
                lane <= lane + 2'd1;
                if (word_full) begin
                    data_out <= {4'b0, pack[31:8], from_ac97_data};
                    address  <= base + words_written;
                    we_ZBT   <= 1'b0;
                    pack     <= '0;
                end else begin
                    case (lane)
                        2'd0:    pack[31:24] <= from_ac97_data;
                        2'd1:    pack[23:16] <= from_ac97_data;
                        default: pack[15:8]  <= from_ac97_data;
                    endcase
                end
            end
            // Unfilled lanes are already zero because pack clears after every write.
            if (flush_issue) begin
                data_out <= {4'b0, pack};
                address  <= base + words_written;
                we_ZBT   <= 1'b0;
                pack     <= '0;
                lane     <= 2'd0;
            end
        end
    end

endmodule
